// File: rtl/rs_syndrome_sequencer.sv
// RS(N,K) syndrome sequencer over GF(8): one shared GF multiply-accumulate evaluates
// every syndrome of a captured codeword by Horner's rule, highest symbol first.
module rs_syndrome_sequencer #(
  parameter int N          = 7,
  parameter int NUM_SYND   = 4,
  parameter int FIRST_ROOT = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [3*N-1:0]          codeword,
  output logic                    busy,
  output logic                    done,
  output logic [3*NUM_SYND-1:0]   syndromes,
  output logic                    error_flag
);

  // state | meaning
  // IDLE  | waiting for start; codeword captured on start
  // CALC  | one Horner step per cycle, syndromes filled in order S0..S(NUM_SYND-1)
  // DONE  | single-cycle done pulse, error_flag valid, then back to IDLE
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int SYM_W  = $clog2(N);
  localparam int SYND_W = $clog2(NUM_SYND) + 1;
  localparam logic [SYM_W-1:0]  SYM_LAST  = SYM_W'(N - 1);
  localparam logic [SYND_W-1:0] SYND_LAST = SYND_W'(NUM_SYND - 1);

  // Polynomial basis, x^3 = x + 1.
  function automatic logic [2:0] gf_mul(input logic [2:0] a, input logic [2:0] b);
    logic [2:0] p;
    logic [2:0] t;
    p = 3'b000;
    t = a;
    for (int i = 0; i < 3; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[1:0], 1'b0} ^ {1'b0, t[2], t[2]};
    end
    return p;
  endfunction

  function automatic logic [2:0] alpha_pow(input int e);
    logic [2:0] r;
    case (e)
      0:       r = 3'b001;
      1:       r = 3'b010;
      2:       r = 3'b100;
      3:       r = 3'b011;
      4:       r = 3'b110;
      5:       r = 3'b111;
      6:       r = 3'b101;
      default: r = 3'b001;
    endcase
    return r;
  endfunction

  state_t              state;
  logic [3*N-1:0]      cw_q;
  logic [SYM_W-1:0]    sym_idx;
  logic [SYND_W-1:0]   synd_idx;
  logic [2:0]          acc;

  logic [2:0]          root;
  logic [2:0]          sym_cur;
  logic [2:0]          step;
  logic [3*NUM_SYND-1:0] synd_next;

  always_comb begin
    root    = 3'b001;
    sym_cur = 3'b000;
    for (int j = 0; j < NUM_SYND; j++)
      if (synd_idx == SYND_W'(j)) root = alpha_pow((FIRST_ROOT + j) % 7);
    for (int i = 0; i < N; i++)
      if (sym_idx == SYM_W'(i)) sym_cur = cw_q[3*i +: 3];
    step      = gf_mul(acc, root) ^ sym_cur;
    synd_next = syndromes;
    if (sym_idx == '0) begin
      for (int j = 0; j < NUM_SYND; j++)
        if (synd_idx == SYND_W'(j)) synd_next[3*j +: 3] = step;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cw_q       <= '0;
      sym_idx    <= '0;
      synd_idx   <= '0;
      acc        <= 3'b000;
      busy       <= 1'b0;
      done       <= 1'b0;
      syndromes  <= '0;
      error_flag <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cw_q     <= codeword;
            sym_idx  <= SYM_LAST;
            synd_idx <= '0;
            acc      <= 3'b000;
            busy     <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          syndromes <= synd_next;
          if (sym_idx != '0) begin
            sym_idx <= sym_idx - 1'b1;
            acc     <= step;
          end else begin
            acc     <= 3'b000;
            sym_idx <= SYM_LAST;
            if (synd_idx == SYND_LAST) begin
              // error_flag taken from the final vector so it is valid together with done
              error_flag <= |synd_next;
              done       <= 1'b1;
              state      <= DONE;
            end else begin
              synd_idx <= synd_idx + 1'b1;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_syndrome_sequencer.sv
// Scoreboard bench for rs_syndrome_sequencer: syndromes predicted by direct polynomial
// evaluation using GF(8) log/antilog tables.
module tb_rs_syndrome_sequencer;

  localparam int N   = 7;
  localparam int NS  = 4;
  localparam int FR  = 1;
  localparam int LAT = N * NS + 1;

  typedef struct {
    logic [3*NS-1:0] synd;
    logic            err;
    int              k;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic [3*N-1:0]  codeword = '0;
  logic            busy, done, error_flag;
  logic [3*NS-1:0] syndromes;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   free_cyc = 0;
  int   last_k = -1000;
  logic prev_done = 1'b0;
  exp_t sb[$];

  logic [2:0] exp_tab [7] = '{3'b001, 3'b010, 3'b100, 3'b011, 3'b110, 3'b111, 3'b101};
  int         log_tab [8] = '{0, 0, 1, 3, 2, 6, 4, 5};

  rs_syndrome_sequencer #(.N(N), .NUM_SYND(NS), .FIRST_ROOT(FR)) dut (
    .clk(clk), .reset(reset), .start(start), .codeword(codeword),
    .busy(busy), .done(done), .syndromes(syndromes), .error_flag(error_flag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3*NS-1:0] model_synd(input logic [3*N-1:0] cw);
    logic [3*NS-1:0] r;
    logic [2:0]      s;
    logic [2:0]      sym;
    r = '0;
    for (int j = 0; j < NS; j++) begin
      s = 3'b000;
      for (int i = 0; i < N; i++) begin
        sym = cw[3*i +: 3];
        if (sym != 3'b000) s = s ^ exp_tab[(log_tab[sym] + ((FR + j) % 7) * i) % 7];
      end
      r[3*j +: 3] = s;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cycle(input int t);
    while (cyc < t) idle(1);
  endtask

  // Presents start for one cycle; the model decides whether the DUT is idle to take it.
  task automatic present(input logic [3*N-1:0] cw);
    exp_t e;
    start    = 1'b1;
    codeword = cw;
    if (cyc >= free_cyc) begin
      e.synd = model_synd(cw);
      e.err  = |e.synd;
      e.k    = cyc;
      sb.push_back(e);
      last_k   = cyc;
      free_cyc = cyc + LAT + 1;
    end
    idle(1);
    start    = 1'b0;
    codeword = 21'($urandom);
  endtask

  always @(negedge clk) begin
    exp_t e;
    check("busy", busy, reset && (cyc > last_k) && (cyc <= last_k + LAT));
    if (done) begin
      if (prev_done) check("done_width", 1, 0);
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("syndromes", syndromes, e.synd);
        check("error_flag", error_flag, e.err);
        check("latency", cyc - e.k, LAT);
      end
    end
    prev_done = done;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_synd", syndromes, 0);
    check("rst_err", error_flag, 0);
    idle(2);
    reset = 1'b1;
    free_cyc = cyc;
    idle(2);

    present(21'h000000);
    idle(LAT + 2);
    present(21'h000001);
    idle(LAT + 2);
    present(21'h000008);
    idle(LAT + 2);
    present(21'h000009);
    idle(LAT + 2);

    // Starts during CALC and on the DONE cycle are dropped; the next IDLE cycle accepts.
    k = cyc;
    present(21'h1234AB);
    wait_cycle(k + 5);
    present(21'h000001);
    wait_cycle(k + LAT);
    present(21'h000008);
    present(21'h0ABCDE);
    idle(LAT + 2);

    // Asynchronous abort in the middle of CALC.
    k = cyc;
    present(21'h000001);
    wait_cycle(k + 10);
    #1;
    reset = 1'b0;
    void'(sb.pop_back());
    last_k = -1000;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_synd", syndromes, 0);
    check("abort_err", error_flag, 0);
    idle(2);
    reset = 1'b1;
    free_cyc = cyc;
    present(21'h000009);
    idle(LAT + 2);

    for (int it = 0; it < 40; it++) begin
      idle($urandom_range(0, 40));
      present(($urandom_range(0, 3) == 0) ? 21'($urandom_range(0, 7) << (3 * $urandom_range(0, N - 1)))
                                           : 21'($urandom));
    end

    for (int t = 0; t < 200 && sb.size() != 0; t++) idle(1);
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
